// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one request per instruction to a
// variable-latency instruction memory, holds the fetched word and advances the PC on Commit.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  input  logic        Commit,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic        Fault
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign PC_plus4  = PC + 32'd4;
  assign imem_addr = PC;

  always_comb begin
    branch_off = {{14{Instr[15]}}, Instr[15:0], 2'b00};
    if (Jump)
      next_pc = {PC_plus4[31:28], Instr[25:0], 2'b00};
    else if (Branch && Zero)
      next_pc = PC_plus4 + branch_off;
    else
      next_pc = PC_plus4;
  end

  // The request pulse is registered on leaving FETCH, so it is visible during the
  // first WAIT cycle, which is also the earliest cycle a response is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      PC          <= RESET_PC;
      imem_req    <= 1'b0;
      Instr       <= '0;
      Instr_valid <= 1'b0;
      Fault       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      imem_req <= 1'b0;
      unique case (state)
        FETCH: begin
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            Instr       <= imem_rdata;
            Instr_valid <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (TIMEOUT != '0 && wait_cnt + 8'd1 == TIMEOUT) begin
              Fault <= 1'b1;
              state <= HALT;
            end
          end
        end
        HOLD: begin
          if (Commit) begin
            PC          <= next_pc;
            Instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end

endmodule
